alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the single-cycle ALU in the EX stage of the pipeline. It takes operands from EX, runs iterative shift-add multiply or restoring divide, and holds results in HI/LO for MFHI/MFLO. A start/busy/done handshake lets the hazard unit stall dependent instructions, and a flush input cancels a speculative operation.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even and >= 4.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising edge of clk
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU
a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
b  input  WIDTH  rt operand (multiplier / divisor)
flush  input  1  abort the in-flight operation
busy  output  1  operation in progress; hazard unit stalls MFHI/MFLO/new muldiv while high
done  output  1  one-cycle pulse; HI/LO updated on the same edge
hi  output  WIDTH  HI register (remainder / product upper half)
lo  output  WIDTH  LO register (quotient / product lower half)

Behaviour:
- Reset, asynchronous on rst_n low: hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0. Reset mid-operation discards the operation.
- FSM states:
  - IDLE: start accepted only in IDLE.
  - CALC: WIDTH iterations, one result bit per cycle.
  - FIX: sign correction and HI/LO write.
- IDLE + start + op MULT/MULTU/DIV/DIVU -> CALC. Operands are latched as magnitudes for the signed ops. busy=1 from the next cycle.
- CALC -> FIX after WIDTH cycles. FIX -> IDLE on the next edge, which writes HI/LO, sets done=1 for exactly one cycle and drops busy.
- Latency: for start sampled at edge E0, HI/LO and done appear after edge E0+WIDTH+1 (33 cycles at WIDTH=32). busy is high for WIDTH+1 cycles.
- MTHI/MTLO in IDLE: hi (or lo) <= a on the same edge, single cycle. No busy, no done.
- start while busy: ignored. The hazard unit is responsible for stalling.
- Multiply result: {hi,lo} = full 2*WIDTH-bit product. MULT is signed, MULTU unsigned.
- Divide: lo = quotient, hi = remainder, truncating toward zero.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) (DIV only).
  - DIV of most-negative by -1: lo = most-negative, hi = 0.
  - Divide by zero, DIV and DIVU: hi = a, lo = all ones. No trap.
- flush=1 while busy: FSM -> IDLE on that edge, busy=0 next cycle, no done, HI/LO unchanged.
- flush=1 in IDLE with start=1: flush wins, request dropped (including MTHI/MTLO).
- flush in the same cycle FIX would write: the write is suppressed.
- Outputs are registered; hi/lo change only on the FIX edge, MTHI/MTLO, or reset.

Optional Feature:
- Macro: ALU_MULDIV_MADD_EN.
- Defined: MADD (signed) and MADDU (unsigned) accumulate, {hi,lo} <= {hi,lo} + a*b modulo 2^(2*WIDTH). The accumulator value is taken at the FIX edge; latency and handshake are identical to MULT.
- Not defined: op 110/111 is treated as no operation. No busy, no done, HI/LO unchanged.

Test Plan:
- Reset mid-DIV: pull rst_n low at cycle 10 -> hi=lo=0, busy=0 immediately; a new MULTU after release completes normally.
- MULT a=0xFFFFFFFE b=3 -> busy for 33 cycles, done pulse, hi=0xFFFFFFFF lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002 lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100 b=0 -> hi=0x00000064, lo=0xFFFFFFFF. MTHI 0x1234 in IDLE -> hi=0x1234 next edge, no done.
- Start DIV, assert flush at cycle 10 -> busy=0 next cycle, done never asserts, hi/lo keep prior values. MTLO and a second start issued while busy -> ignored.
- With ALU_MULDIV_MADD_EN: hi=0 lo=0xFFFFFFFF, MADDU a=1 b=1 -> hi=1 lo=0. Without the macro, the same op -> no busy, HI/LO unchanged.

Source files
------------

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply, restoring divide.
// Optional MADD/MADDU accumulate is enabled by defining ALU_MULDIV_MADD_EN.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem, r_q, r_b, r_a;
  logic               r_div, r_div0, r_neg_q, r_neg_r;

  logic               w_is_mul, w_is_div, w_is_madd, w_is_mt, w_idle_req, w_go, w_signed;
  logic               w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_mul_sum, w_div_sh;
  logic               w_div_ok;
  logic [WIDTH-1:0]   w_div_sub, w_quo, w_remd, w_res_hi, w_res_lo;
  logic [2*WIDTH-1:0] w_prod, w_prod_s, w_mul_res;

  assign w_is_mul   = (op[2:1] == 2'b00);
  assign w_is_div   = (op[2:1] == 2'b01);
  assign w_is_mt    = (op[2:1] == 2'b10);
`ifdef ALU_MULDIV_MADD_EN
  logic r_madd;
  assign w_is_madd  = (op[2:1] == 2'b11);
`else
  assign w_is_madd  = 1'b0;
`endif
  assign w_idle_req = (r_state == S_IDLE) && start && !flush;
  assign w_go       = w_idle_req && (w_is_mul || w_is_div || w_is_madd);
  assign w_signed   = ~op[0];
  assign w_neg_a    = w_signed & a[WIDTH-1];
  assign w_neg_b    = w_signed & b[WIDTH-1];
  assign w_mag_a    = w_neg_a ? -a : a;
  assign w_mag_b    = w_neg_b ? -b : b;

  // One iteration of each algorithm; r_q holds multiplier / dividend-becoming-quotient.
  assign w_mul_sum = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_b} : '0);
  assign w_div_sh  = {r_rem, r_q[WIDTH-1]};
  assign w_div_ok  = (w_div_sh >= {1'b0, r_b});
  assign w_div_sub = w_div_sh[WIDTH-1:0] - r_b;

  assign w_prod   = {r_rem, r_q};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
`ifdef ALU_MULDIV_MADD_EN
  assign w_mul_res = w_prod_s + (r_madd ? {hi, lo} : '0);
`else
  assign w_mul_res = w_prod_s;
`endif
  assign w_quo  = r_neg_q ? -r_q : r_q;
  assign w_remd = r_neg_r ? -r_rem : r_rem;

  always_comb begin
    w_res_hi = w_mul_res[2*WIDTH-1:WIDTH];
    w_res_lo = w_mul_res[WIDTH-1:0];
    if (r_div) begin
      w_res_hi = r_div0 ? r_a : w_remd;
      w_res_lo = r_div0 ? '1  : w_quo;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_go) w_next = S_CALC;
      S_CALC: begin
        if (flush)                             w_next = S_IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1))   w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0; r_rem <= '0; r_q <= '0; r_b <= '0; r_a <= '0;
      r_div <= 1'b0; r_div0 <= 1'b0; r_neg_q <= 1'b0; r_neg_r <= 1'b0;
`ifdef ALU_MULDIV_MADD_EN
      r_madd <= 1'b0;
`endif
      busy <= 1'b0; done <= 1'b0; hi <= '0; lo <= '0;
    end else begin
      busy <= (w_next != S_IDLE);
      done <= (r_state == S_FIX) && !flush;
      if (w_go) begin
        r_cnt   <= '0;
        r_rem   <= '0;
        r_a     <= a;
        r_div   <= w_is_div;
        r_div0  <= (b == '0);
        r_neg_q <= w_neg_a ^ w_neg_b;
        r_neg_r <= w_neg_a;
        r_q     <= w_is_div ? w_mag_a : w_mag_b;
        r_b     <= w_is_div ? w_mag_b : w_mag_a;
`ifdef ALU_MULDIV_MADD_EN
        r_madd  <= w_is_madd;
`endif
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_div) begin
          r_rem <= w_div_ok ? w_div_sub : w_div_sh[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_div_ok};
        end else begin
          r_rem <= w_mul_sum[WIDTH:1];
          r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
        end
      end
      if (r_state == S_FIX && !flush) begin
        hi <= w_res_hi;
        lo <= w_res_lo;
      end else if (w_idle_req && w_is_mt) begin
        if (op[0]) lo <= a;
        else       hi <= a;
      end
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv at WIDTH=32; MADD checks follow ALU_MULDIV_MADD_EN.
module tb_alu_muldiv;
  localparam int W = 32;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  int checks = 0, errors = 0;

  alu_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk); op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  // Counts edges after the issue edge until done, and post-edge samples with busy high.
  task automatic wait_done(output int lat, output int bcnt, output bit got);
    lat = 0; bcnt = 0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (busy) bcnt++;
      if (done) got = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int bcnt, output bit got);
    issue(o, x, y);
    wait_done(lat, bcnt, got);
  endtask

  task automatic test_reset;
    int lat, bc; bit got;
    #1;
    checks++; if (hi !== 0 || lo !== 0) begin errors++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
    checks++; if (busy !== 0 || done !== 0) begin errors++; $display("FAIL reset_ctl got busy=%b done=%b want 0/0", busy, done); end
    @(negedge clk); rst_n = 1'b1;
    issue(3'b100, 32'h55, 0);
    issue(3'b010, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    checks++; if (hi !== 0 || lo !== 0 || busy !== 0) begin errors++; $display("FAIL reset_mid got hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy); end
    @(negedge clk); rst_n = 1'b1;
    run_op(3'b001, 32'd7, 32'd6, lat, bc, got);
    checks++; if (!got || hi !== 0 || lo !== 32'd42) begin errors++; $display("FAIL reset_after_multu got done=%b %h/%h want 1 0/2a", got, hi, lo); end
  endtask

  task automatic test_mult;
    int lat, bc; bit got;
    run_op(3'b000, 32'hFFFFFFFE, 32'd3, lat, bc, got);
    checks++; if (!got || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult got %h/%h want ffffffff/fffffffa", hi, lo); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d want 33", lat); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d want 33", bc); end
    @(posedge clk); #1;
    checks++; if (done !== 0 || busy !== 0) begin errors++; $display("FAIL done_pulse got done=%b busy=%b want 0/0", done, busy); end
    run_op(3'b001, 32'hFFFFFFFE, 32'd3, lat, bc, got);
    checks++; if (!got || hi !== 32'h2 || lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu got %h/%h want 00000002/fffffffa", hi, lo); end
    run_op(3'b000, 32'hFFFFFFFB, 32'hFFFFFFF9, lat, bc, got);
    checks++; if (!got || hi !== 0 || lo !== 32'd35) begin errors++; $display("FAIL mult_negneg got %h/%h want 0/23", hi, lo); end
  endtask

  task automatic test_div;
    int lat, bc; bit got;
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, lat, bc, got);
    checks++; if (!got || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg got lo=%h hi=%h want fffffffd/ffffffff", lo, hi); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, lat, bc, got);
    checks++; if (!got || lo !== 32'h80000000 || hi !== 0) begin errors++; $display("FAIL div_ovf got lo=%h hi=%h want 80000000/0", lo, hi); end
    run_op(3'b011, 32'd100, 32'd0, lat, bc, got);
    checks++; if (!got || hi !== 32'h64 || lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_zero got hi=%h lo=%h want 64/ffffffff", hi, lo); end
    run_op(3'b010, 32'hFFFFFFF8, 32'd0, lat, bc, got);
    checks++; if (!got || hi !== 32'hFFFFFFF8 || lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_zero got hi=%h lo=%h want fffffff8/ffffffff", hi, lo); end
    run_op(3'b010, 32'd7, 32'hFFFFFFFE, lat, bc, got);
    checks++; if (!got || lo !== 32'hFFFFFFFD || hi !== 32'd1) begin errors++; $display("FAIL div_negdiv got lo=%h hi=%h want fffffffd/1", lo, hi); end
    run_op(3'b011, 32'hFFFFFFFF, 32'd16, lat, bc, got);
    checks++; if (!got || lo !== 32'h0FFFFFFF || hi !== 32'hF) begin errors++; $display("FAIL divu got lo=%h hi=%h want 0fffffff/f", lo, hi); end
  endtask

  task automatic test_mt;
    issue(3'b100, 32'h1234, 0);
    checks++; if (hi !== 32'h1234 || done !== 0 || busy !== 0) begin errors++; $display("FAIL mthi got hi=%h done=%b busy=%b want 1234/0/0", hi, done, busy); end
    issue(3'b101, 32'hABCD, 0);
    checks++; if (lo !== 32'hABCD || hi !== 32'h1234 || done !== 0) begin errors++; $display("FAIL mtlo got lo=%h hi=%h done=%b want abcd/1234/0", lo, hi, done); end
    @(negedge clk); op = 3'b100; a = 32'h7777; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL flush_idle got hi=%h want 1234", hi); end
  endtask

  task automatic test_flush;
    int lat, bc; bit got; bit seen;
    issue(3'b100, 32'hAAAA, 0);
    issue(3'b101, 32'hBBBB, 0);
    issue(3'b010, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (busy !== 0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    checks++; if (seen || hi !== 32'hAAAA || lo !== 32'hBBBB) begin errors++; $display("FAIL flush_calc got done_seen=%b %h/%h want 0 aaaa/bbbb", seen, hi, lo); end
    issue(3'b001, 32'd5, 32'd5);
    repeat (W) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (done !== 0 || busy !== 0 || hi !== 32'hAAAA || lo !== 32'hBBBB) begin errors++; $display("FAIL flush_fix got done=%b busy=%b %h/%h want 0/0 aaaa/bbbb", done, busy, hi, lo); end
  endtask

  task automatic test_back_to_back;
    int lat, bc; bit got;
    issue(3'b001, 32'd3, 32'd4);
    repeat (3) @(posedge clk);
    issue(3'b101, 32'h99, 0);
    checks++; if (lo !== 32'hBBBB) begin errors++; $display("FAIL mt_while_busy got lo=%h want bbbb", lo); end
    issue(3'b011, 32'd50, 32'd7);
    wait_done(lat, bc, got);
    checks++; if (!got || hi !== 0 || lo !== 32'd12) begin errors++; $display("FAIL busy_ignore got done=%b %h/%h want 1 0/c", got, hi, lo); end
    @(posedge clk); #1;
    checks++; if (busy !== 0) begin errors++; $display("FAIL second_start got busy=%b want 0", busy); end
  endtask

  task automatic test_madd;
    int lat, bc; bit got;
    issue(3'b100, 32'h0, 0);
    issue(3'b101, 32'hFFFFFFFF, 0);
`ifdef ALU_MULDIV_MADD_EN
    run_op(3'b111, 32'd1, 32'd1, lat, bc, got);
    checks++; if (!got || hi !== 32'd1 || lo !== 0 || lat !== 33) begin errors++; $display("FAIL maddu got done=%b lat=%0d %h/%h want 1 33 1/0", got, lat, hi, lo); end
    run_op(3'b110, 32'hFFFFFFFF, 32'd1, lat, bc, got);
    checks++; if (!got || hi !== 0 || lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL madd got %h/%h want 0/ffffffff", hi, lo); end
`else
    issue(3'b111, 32'd1, 32'd1);
    checks++; if (busy !== 0 || done !== 0) begin errors++; $display("FAIL madd_nop_ctl got busy=%b done=%b want 0/0", busy, done); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (done !== 0 || hi !== 0 || lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL madd_nop got done=%b %h/%h want 0 0/ffffffff", done, hi, lo); end
`endif
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_mt;
    test_flush;
    test_back_to_back;
    test_madd;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
